cpu_control_fsm: RTL and testbench

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

---
 rtl/cpu_control_fsm.sv | 104 ++++++++++
 tb/tb_cpu_control_fsm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/read/exec/writeback sequencer for a small MIPS subset.
// Define CTRL_ILLEGAL_TRAP_EN to halt on unlisted opcodes instead of retiring them as NOPs.
module cpu_control_fsm #(
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] pc,
    output logic        pc_en,
    output logic        pc_jmp,
    output logic [31:0] pc_target,
    output logic [4:0]  rf_selA,
    output logic [4:0]  rf_selB,
    output logic [4:0]  rf_selW,
    output logic        rf_we,
    output logic [31:0] rf_inW,
    input  logic [31:0] rf_outA,
    input  logic [31:0] rf_outB,
    output logic [3:0]  alu_funct,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    output logic [2:0]  state,
    output logic        halted,
    output logic        retired
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        READ   = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd6
    } state_t;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int CW = $clog2(FETCH_TIMEOUT + 1);
    state_t cur, nxt;
    logic [31:0] instr, imm_sx, pc_plus4;
    logic [CW-1:0] cnt;
    logic [5:0] op, fn;
    logic [4:0] rd;
    logic is_r, is_addiu, is_beq, is_j, legal, wr, in_ex, in_wb, taken;
    logic unused_ok;
    assign unused_ok = ^rf_outA;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur   <= FETCH;
            instr <= '0;
            cnt   <= '0;
        end else begin
            cur <= nxt;
            if (cur == FETCH && imem_ack) instr <= imem_rdata;
            cnt <= (cur == FETCH && !imem_ack) ? cnt + 1'b1 : '0;
        end
    end
    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:   nxt = imem_ack ? DECODE : (cnt == CW'(FETCH_TIMEOUT - 1)) ? HALT : FETCH;
            DECODE:  nxt = (TRAP && !legal) ? HALT : READ;
            READ:    nxt = EXEC;
            EXEC:    nxt = WB;
            WB:      nxt = FETCH;
            default: nxt = HALT;
        endcase
    end
    assign op       = instr[31:26];
    assign fn       = instr[5:0];
    assign is_r     = op == 6'h00 && (fn == 6'h21 || fn == 6'h23 || fn == 6'h24);
    assign is_addiu = op == 6'h09;
    assign is_beq   = op == 6'h04;
    assign is_j     = op == 6'h02;
    assign legal    = is_r || is_addiu || is_beq || is_j;
    assign wr       = is_r || is_addiu;
    assign rd       = is_r ? instr[15:11] : instr[20:16];
    assign imm_sx   = {{16{instr[15]}}, instr[15:0]};
    assign pc_plus4 = pc + 32'd4;
    assign in_ex    = cur == EXEC || cur == WB;
    assign in_wb    = cur == WB;
    assign taken    = is_j || (is_beq && alu_out == 32'd0);
    // imem_req is gated by reset so it stays low while reset is held even though state reads FETCH
    assign imem_req  = cur == FETCH && reset;
    assign state     = cur;
    assign halted    = cur == HALT;
    assign rf_selA   = instr[25:21];
    assign rf_selB   = instr[20:16];
    assign alu_funct = !in_ex ? 4'd0 : is_r ? (fn == 6'h21 ? 4'd1 : fn == 6'h23 ? 4'd2 : 4'd3) :
                       is_addiu ? 4'd1 : is_beq ? 4'd2 : 4'd0;
    assign alu_b     = !in_ex ? 32'd0 : is_addiu ? imm_sx : (is_r || is_beq) ? rf_outB : 32'd0;
    assign retired   = in_wb;
    assign pc_en     = in_wb;
    assign rf_we     = in_wb && wr && rd != 5'd0;
    assign rf_selW   = (in_wb && wr) ? rd : 5'd0;
    assign rf_inW    = (in_wb && wr) ? alu_out : 32'd0;
    assign pc_jmp    = in_wb && taken;
    assign pc_target = !pc_jmp ? 32'd0 : is_j ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                       pc_plus4 + {imm_sx[29:0], 2'b00};
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: random and directed instruction stream checked against an ISA-level model.
module tb_cpu_control_fsm;
    logic clk = 0, reset = 0;
    logic imem_req, imem_ack, pc_en, pc_jmp, rf_we, halted, retired;
    logic [31:0] imem_rdata, pc, pc_target, rf_inW, rf_outA, rf_outB, alu_b, alu_out;
    logic [4:0] rf_selA, rf_selB, rf_selW;
    logic [3:0] alu_funct;
    logic [2:0] state;
    logic [31:0] regs [32];
    int n_chk = 0, n_pass = 0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    cpu_control_fsm dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(pc), .pc_en(pc_en), .pc_jmp(pc_jmp), .pc_target(pc_target),
        .rf_selA(rf_selA), .rf_selB(rf_selB), .rf_selW(rf_selW), .rf_we(rf_we), .rf_inW(rf_inW),
        .rf_outA(rf_outA), .rf_outB(rf_outB), .alu_funct(alu_funct), .alu_b(alu_b), .alu_out(alu_out),
        .state(state), .halted(halted), .retired(retired)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        rf_outA <= regs[rf_selA];
        rf_outB <= regs[rf_selB];
    end
    always_comb
        alu_out = alu_funct == 4'd1 ? rf_outA + alu_b : alu_funct == 4'd2 ? rf_outA - alu_b :
                  alu_funct == 4'd3 ? (rf_outA & alu_b) : 32'd0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic check_quiet(input string tag);
        check({tag, "_we"}, rf_we, 0);
        check({tag, "_pc_en"}, pc_en, 0);
        check({tag, "_jmp"}, pc_jmp, 0);
        check({tag, "_ret"}, retired, 0);
    endtask
    task automatic run(input logic [31:0] ins, input int dly);
        logic [31:0] a, b, sx, res, tgt;
        logic [4:0] rd;
        logic [3:0] f;
        logic wr, jmp, legal;
        a = regs[ins[25:21]];
        b = regs[ins[20:16]];
        sx = {{16{ins[15]}}, ins[15:0]};
        {res, tgt, rd, f, wr, jmp, legal} = '0;
        legal = 1;
        if (ins[31:26] == 0 && ins[5:0] == 6'h21) begin f = 1; wr = 1; rd = ins[15:11]; res = a + b; end
        else if (ins[31:26] == 0 && ins[5:0] == 6'h23) begin f = 2; wr = 1; rd = ins[15:11]; res = a - b; end
        else if (ins[31:26] == 0 && ins[5:0] == 6'h24) begin f = 3; wr = 1; rd = ins[15:11]; res = a & b; end
        else if (ins[31:26] == 6'h09) begin f = 1; wr = 1; rd = ins[20:16]; res = a + sx; end
        else if (ins[31:26] == 6'h04) begin f = 2; jmp = a == b; tgt = pc + 4 + sx * 4; end
        else if (ins[31:26] == 6'h02) begin jmp = 1; tgt = ((pc + 4) & 32'hF000_0000) + {6'd0, ins[25:0]} * 4; end
        else legal = 0;
        for (int k = 0; k <= dly; k++) begin
            @(negedge clk);
            check("fetch_state", state, 0);
            check("fetch_req", imem_req, 1);
            check("fetch_funct", alu_funct, 0);
            imem_ack = k == dly;
            imem_rdata = k == dly ? ins : $urandom;
        end
        @(negedge clk);
        check("dec_state", state, 1);
        check("dec_selA", rf_selA, ins[25:21]);
        check("dec_selB", rf_selB, ins[20:16]);
        imem_ack = 1'($urandom);
        imem_rdata = $urandom;
        if (TRAP && !legal) begin
            @(negedge clk);
            check("trap_state", state, 6);
            check("trap_halted", halted, 1);
            check_quiet("trap");
            imem_ack = 0;
            return;
        end
        @(negedge clk);
        check("read_state", state, 2);
        check("read_selA", rf_selA, ins[25:21]);
        check("read_funct", alu_funct, 0);
        @(negedge clk);
        check("exec_state", state, 3);
        check("exec_funct", alu_funct, f);
        check_quiet("exec");
        @(negedge clk);
        check("wb_state", state, 4);
        check("wb_funct", alu_funct, f);
        check("wb_selB", rf_selB, ins[20:16]);
        check("wb_retired", retired, 1);
        check("wb_pc_en", pc_en, 1);
        check("wb_we", rf_we, wr && rd != 0);
        if (wr && rd != 0) begin
            check("wb_selW", rf_selW, rd);
            check("wb_inW", rf_inW, res);
            regs[rd] = res;
        end
        check("wb_jmp", pc_jmp, jmp);
        if (jmp) check("wb_target", pc_target, tgt);
        pc = jmp ? tgt : pc + 4;
        imem_ack = 0;
    endtask
    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 0;
        #1;
        check("rst_state", state, 0);
        check("rst_req", imem_req, 0);
        check("rst_halted", halted, 0);
        check_quiet("rst");
        repeat (cycles) @(negedge clk);
        reset = 1;
        #1;
        check("rel_state", state, 0);
        check("rel_req", imem_req, 1);
    endtask
    function automatic logic [31:0] gen();
        logic [4:0] rs, rt, rd;
        int t;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        t = TRAP ? $urandom_range(0, 5) : $urandom_range(0, 6);
        case (t)
            0: return {6'd0, rs, rt, rd, 5'd0, 6'h21};
            1: return {6'd0, rs, rt, rd, 5'd0, 6'h23};
            2: return {6'd0, rs, rt, rd, 5'd0, 6'h24};
            3: return {6'h09, rs, rt, 16'($urandom)};
            4: return {6'h04, rs, $urandom_range(0, 1) ? rs : rt, 16'($urandom)};
            5: return {6'h02, 26'($urandom)};
            default: return $urandom_range(0, 1) ? {6'h3F, 26'($urandom)} : {6'd0, rs, rt, rd, 5'd0, 6'h20};
        endcase
    endfunction
    initial begin
        imem_ack = 0;
        imem_rdata = 0;
        pc = 32'h100;
        for (int i = 0; i < 32; i++) regs[i] = i == 0 ? 0 : $urandom;
        regs[1] = 5;
        regs[2] = 7;
        do_reset(2);
        run({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 2);
        check("addu_r3", regs[3], 12);
        run({6'h09, 5'd1, 5'd0, 16'hFFFF}, 0);
        regs[2] = 5;
        pc = 32'h100;
        run({6'h04, 5'd1, 5'd2, 16'd4}, 1);
        check("beq_pc", pc, 32'h114);
        regs[2] = 7;
        run({6'h04, 5'd1, 5'd2, 16'd4}, 0);
        check("bne_pc", pc, 32'h118);
        pc = 32'hF000_0000;
        run({6'h02, 26'h40}, 0);
        check("j_pc", pc, 32'hF000_0100);
        for (int n = 0; n < 80; n++) run(gen(), $urandom_range(0, 4));
        run({6'h3F, 26'h123}, 1);
        if (TRAP) do_reset(1);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("to_state", state, 0);
            imem_ack = 0;
        end
        @(negedge clk);
        check("to_halt", state, 6);
        check("to_halted", halted, 1);
        check("to_req", imem_req, 0);
        imem_ack = 1;
        imem_rdata = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
        @(negedge clk);
        check("halt_stuck", state, 6);
        check_quiet("halt");
        imem_ack = 0;
        do_reset(1);
        run({6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'h23}, 0);
        @(negedge clk);
        imem_ack = 1;
        imem_rdata = {6'd0, 5'd1, 5'd2, 5'd5, 5'd0, 6'h21};
        @(negedge clk);
        imem_ack = 0;
        repeat (2) @(negedge clk);
        check("mid_exec", state, 3);
        reset = 0;
        #1;
        check_quiet("mid_rst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_quiet("mid_hold");
        end
        reset = 1;
        run({6'h09, 5'd2, 5'd6, 16'h0003}, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
